// File: rtl/pwm_led_ctrl.sv
// N-channel PWM LED controller: register port, prescaler, shared period counter,
// per-channel duty shadows reloaded on period boundaries, optional breathe ramp.

// One PWM channel: active duty register, breathe level/direction, output flop.
module pwm_led_ch #(
  parameter int CNT_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             en,
  input  logic             breathe,
  input  logic             boundary,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W:0]   shadow,
  output logic             pwm
);
  localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};

  logic [CNT_W:0] duty_c, active, level, level_nxt;
  logic           dir, dir_nxt; // 0 = ramping up, 1 = ramping down

  // Anything above 100% is treated as 100%
  assign duty_c = (shadow > FULL) ? FULL : shadow;

  // Next breathe step, taken only on a period boundary
  always_comb begin
    level_nxt = level;
    dir_nxt   = dir;
    if (duty_c == '0) begin
      level_nxt = '0;
      dir_nxt   = 1'b0;
    end else if (!dir) begin
      if (level + 1'b1 >= duty_c) begin
        level_nxt = duty_c;
        dir_nxt   = 1'b1;
      end else begin
        level_nxt = level + 1'b1;
      end
    end else begin
      if (level <= 1) begin
        level_nxt = '0;
        dir_nxt   = 1'b0;
      end else begin
        level_nxt = level - 1'b1;
      end
    end
  end

  // Breathe state parks at 0/UP whenever disabled or not in breathe mode
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      level <= '0;
      dir   <= 1'b0;
    end else if (!en || !breathe) begin
      level <= '0;
      dir   <= 1'b0;
    end else if (boundary) begin
      level <= level_nxt;
      dir   <= dir_nxt;
    end
  end

  // Active duty tracks the shadow while idle so the first enabled period is correct
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)      active <= '0;
    else if (!en)      active <= breathe ? '0 : duty_c;
    else if (boundary) active <= breathe ? level_nxt : duty_c;
  end

  // Registered compare keeps the pad glitch-free
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) pwm <= 1'b0;
    else          pwm <= en & ({1'b0, cnt} < active);
  end
endmodule

module pwm_led_ctrl #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8,
  parameter int PSC_W  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);
  logic                         en;
  logic [NUM_CH-1:0]            breathe;
  logic [PSC_W-1:0]             psc, psc_cnt;
  logic [NUM_CH-1:0][CNT_W:0]   shadow;
  logic [CNT_W-1:0]             cnt;
  logic                         tick, boundary, psc_wr;
  logic                         unused_wr_bits;

  assign unused_wr_bits = &{1'b0, wr_data};
  assign psc_wr      = wr_en && (wr_addr == ADDR_W'(1));
  assign tick        = en && (psc_cnt == psc);
  assign boundary    = tick && (cnt == {CNT_W{1'b1}});
  assign period_tick = boundary;

  // Register writes; unmapped addresses fall through untouched
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en      <= 1'b0;
      breathe <= '0;
      psc     <= '0;
      shadow  <= '0;
    end else if (wr_en) begin
      if (wr_addr == '0) begin
        en      <= wr_data[0];
        breathe <= wr_data[NUM_CH+7:8];
      end
      if (psc_wr) psc <= wr_data[PSC_W-1:0];
      for (int i = 0; i < NUM_CH; i++)
        if (wr_addr == ADDR_W'(i + 2)) shadow[i] <= wr_data[CNT_W:0];
    end
  end

  // Prescaler and period counter; both sit at 0 while disabled
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      psc_cnt <= '0;
      cnt     <= '0;
    end else if (!en) begin
      psc_cnt <= '0;
      cnt     <= '0;
    end else begin
      if (psc_wr || tick) psc_cnt <= '0;
      else                psc_cnt <= psc_cnt + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
    end
  end

  // Side-effect-free combinational readback
  always_comb begin
    rd_data = '0;
    if (rd_addr == '0) begin
      rd_data[0]          = en;
      rd_data[NUM_CH+7:8] = breathe;
    end
    if (rd_addr == ADDR_W'(1)) rd_data[PSC_W-1:0] = psc;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_addr == ADDR_W'(i + 2)) rd_data[CNT_W:0] = shadow[i];
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_led_ch #(.CNT_W(CNT_W)) u_ch (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .en       (en),
      .breathe  (breathe[g]),
      .boundary (boundary),
      .cnt      (cnt),
      .shadow   (shadow[g]),
      .pwm      (pwm_out[g])
    );
  end
endmodule

// File: tb/tb_pwm_led_ctrl.sv
// Bench for pwm_led_ctrl: per-period high-time and period-spacing model plus directed register checks.
module tb_pwm_led_ctrl;
  localparam int NCH = 3, CW = 4, PW = 16, AW = 4, FULL = 16;

  logic          HCLK = 0, HRESETn = 0, wr_en = 0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  logic [NCH-1:0] pwm_out;
  logic          period_tick;

  pwm_led_ctrl #(.NUM_CH(NCH), .CNT_W(CW), .PSC_W(PW), .ADDR_W(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .pwm_out(pwm_out), .period_tick(period_tick));

  always #5 HCLK = ~HCLK;

  int n_cmp = 0, n_bad = 0;

  // reference model state
  int m_psc = 0;
  int m_duty [NCH];
  bit [NCH-1:0] m_brth = '0;

  // monitor state
  bit mon_on = 0, close_now = 0;
  int samp = 0, last_tick = 0, per = 0;
  int acc [NCH], exp_hi [NCH], nxt_hi [NCH];

  function automatic int clampd(int d);
    return (d > FULL) ? FULL : d;
  endfunction

  // High cycles in period p: triangle wave 0..c..0 in breathe mode, else clamped duty
  function automatic int exp_high(int p, int ch);
    int c, lvl, m;
    c = clampd(m_duty[ch]);
    if (!m_brth[ch])  lvl = c;
    else if (c == 0)  lvl = 0;
    else begin
      m   = p % (2 * c);
      lvl = (m <= c) ? m : 2 * c - m;
    end
    return lvl * (m_psc + 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // pwm_out lags the counter by one cycle, so a period's window closes one sample after its tick
  always @(negedge HCLK) begin
    if (mon_on) begin
      samp++;
      for (int c = 0; c < NCH; c++) acc[c] += int'(pwm_out[c]);
      if (close_now) begin
        for (int c = 0; c < NCH; c++) begin
          chk($sformatf("high_p%0d_ch%0d", per, c), acc[c], exp_hi[c]);
          acc[c]    = 0;
          exp_hi[c] = nxt_hi[c];
        end
        per++;
        close_now = 0;
      end
      if (period_tick) begin
        chk($sformatf("tick_gap_p%0d", per), samp - last_tick, 16 * (m_psc + 1));
        last_tick = samp;
        close_now = 1;
        for (int c = 0; c < NCH; c++) nxt_hi[c] = exp_high(per + 1, c);
      end
    end
  end

  // Drive one write (now=1: in the current cycle), model updates after it commits
  task automatic wr(int a, logic [31:0] d, bit now = 0);
    if (!now) @(negedge HCLK);
    wr_en = 1; wr_addr = a[AW-1:0]; wr_data = d;
    @(posedge HCLK); #1;
    wr_en = 0;
    if (a == 1) m_psc = int'(d[PW-1:0]);
    else if (a >= 2 && a < 2 + NCH) m_duty[a-2] = int'(d[CW:0]);
  endtask

  task automatic rd_chk(int a, logic [31:0] expv, string tag);
    rd_addr = a[AW-1:0];
    #1;
    chk(tag, rd_data, expv);
  endtask

  task automatic start(int psc, int d0, int d1, int d2, bit [2:0] br);
    wr(1, psc); wr(2, d0); wr(3, d1); wr(4, d2);
    m_brth = br;
    wr(0, 32'(br) << 8);
    wr(0, (32'(br) << 8) | 32'h1);
    samp = 0; last_tick = 0; per = 0; close_now = 0;
    for (int c = 0; c < NCH; c++) begin acc[c] = 0; exp_hi[c] = exp_high(0, c); end
    mon_on = 1;
  endtask

  task automatic run(int np);
    int budget;
    budget = np * 16 * (m_psc + 1) + 64;
    while (per < np && budget > 0) begin @(negedge HCLK); budget--; end
    chk("run_done", per >= np, 1);
  endtask

  task automatic stop();
    mon_on = 0;
    wr(0, 0);
    m_brth = '0;
  endtask

  initial begin
    int b, tgt;
    bit seen;
    for (int c = 0; c < NCH; c++) m_duty[c] = 0;
    repeat (3) @(posedge HCLK); #1;
    chk("rst_pwm", pwm_out, 0);
    chk("rst_tick", period_tick, 0);
    @(negedge HCLK) HRESETn = 1;
    for (int a = 0; a < 16; a++) rd_chk(a, 0, $sformatf("rst_rd%0d", a));

    // register map
    wr(0, 32'hFFFF_FFFE); rd_chk(0, 32'h0000_0700, "ctrl_rd");
    wr(0, 0);
    wr(1, 32'hABCD_1234); rd_chk(1, 32'h0000_1234, "psc_rd");
    wr(2, 32'hFFFF_FFF5); rd_chk(2, 21, "duty0_rd");
    wr(7, 32'hFF); wr(15, 32'hFF);
    rd_chk(7, 0, "unmapped7"); rd_chk(15, 0, "unmapped15"); rd_chk(3, 0, "duty1_kept");

    // duty 4 / 100% / clamped, then prescale 2 with duty 0 / 8
    start(0, 4, 16, 31, 3'b000); run(3); stop();
    start(2, 0, 8, 5, 3'b000);   run(2); stop();
    // breathe ramp on channel 2
    start(0, 4, 8, 3, 3'b100);   run(8); stop();

    // mid-period duty change, then a write in the boundary cycle
    start(0, 4, 4, 4, 3'b000);
    repeat (5) @(negedge HCLK);
    wr(2, 12);
    run(3);
    b = 200;
    do begin @(negedge HCLK); b--; end while (!period_tick && b > 0);
    chk("wait_tick", period_tick, 1);
    tgt = per + 3;
    wr(2, 4, 1);
    run(tgt);
    stop();

    // randomized configurations
    for (int it = 0; it < 6; it++) begin
      start($urandom_range(0, 2), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), 3'($urandom));
      run(5);
      stop();
    end

    // disable: outputs quiet, shadows retained
    start(0, 7, 16, 2, 3'b000); run(1);
    mon_on = 0;
    wr(0, 0);
    @(posedge HCLK); #1;
    seen = 0;
    repeat (40) begin @(negedge HCLK); seen |= (pwm_out != 0) || period_tick; end
    chk("en0_quiet", seen, 0);
    rd_chk(2, 7, "en0_duty0"); rd_chk(3, 16, "en0_duty1"); rd_chk(4, 2, "en0_duty2");

    // async reset mid-period
    start(0, 7, 16, 2, 3'b000);
    repeat (5) @(negedge HCLK);
    mon_on = 0;
    chk("pre_rst_hi", pwm_out[1], 1);
    #2 HRESETn = 0;
    #1;
    chk("arst_pwm", pwm_out, 0);
    chk("arst_tick", period_tick, 0);
    rd_chk(0, 0, "arst_ctrl"); rd_chk(1, 0, "arst_psc"); rd_chk(3, 0, "arst_duty1");
    m_psc = 0; m_brth = '0;
    for (int c = 0; c < NCH; c++) m_duty[c] = 0;
    @(negedge HCLK) HRESETn = 1;
    start(1, 10, 3, 16, 3'b000); run(2); stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
